// File: rtl/sequential_isqrt_pkg.sv
// Shared types and constants for the sequential integer square-root unit.
// Holds the FSM state encoding, the root-width helper and the reset values.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam state_e RST_STATE     = IDLE;
    localparam logic   RST_IN_READY  = 1'b1;
    localparam logic   RST_OUT_VALID = 1'b0;
    localparam logic   RST_OUT_EXACT = 1'b0;

    // Number of root bits (and iterations) for a given radicand width.
    function automatic int root_width(input int width);
        return width / 2;
    endfunction

    // Bits needed to hold the step counter values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sequential_isqrt_if.sv
// Producer/consumer handshake bundle for sequential_isqrt.
// out_exact exists only when SQRT_EXACT_FLAG_EN is defined.
interface sequential_isqrt_if #(
    parameter int WIDTH = 6
);
    localparam int N = sqrt_pkg::root_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_root;
    logic [N:0]       out_rem;
`ifdef SQRT_EXACT_FLAG_EN
    logic             out_exact;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_root, out_rem, out_exact
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_root, out_rem, out_exact
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_root, out_rem
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_root, out_rem
    );
`endif

endinterface

// File: rtl/sequential_isqrt_step.sv
// One restoring digit-by-digit square-root iteration (purely combinational).
// Consumes the next two radicand bits and produces the updated remainder and root.
module isqrt_step #(
    parameter int N = 3
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [1:0]   x_bits,
    output logic [N:0]   r_nxt,
    output logic [N-1:0] q_nxt
);
    localparam int TW = N + 3;
    localparam int RW = N + 1;

    logic [TW-1:0] t_s;
    logic [TW-1:0] d_s;
    logic          ge_s;

    // Trial subtraction of (4Q+1) from the shifted remainder; the result fits in N+1 bits.
    always_comb begin
        t_s  = {r, x_bits};
        d_s  = {1'b0, q, 2'b01};
        ge_s = (t_s >= d_s);
        if (ge_s) begin
            r_nxt = RW'(t_s - d_s);
        end else begin
            r_nxt = t_s[N:0];
        end
        q_nxt = N'({q, ge_s});
    end

endmodule

// File: rtl/sequential_isqrt.sv
// Iterative floor square root with remainder, one root bit per clock, valid/ready on both sides.
// Optional out_exact flag is built when SQRT_EXACT_FLAG_EN is defined.
module sequential_isqrt
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    sequential_isqrt_if.slave  bus
);
    localparam int N  = root_width(WIDTH);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] x_r;
    logic [N:0]       r_r;
    logic [N-1:0]     q_r;
    logic [CW-1:0]    cnt_r;
    logic [N:0]       r_step_s;
    logic [N-1:0]     q_step_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;

    logic             in_ready_r;
    logic             out_valid_r;
    logic [N-1:0]     out_root_r;
    logic [N:0]       out_rem_r;

    isqrt_step #(.N(N)) u_step (
        .r      (r_r),
        .q      (q_r),
        .x_bits (x_r[WIDTH-1:WIDTH-2]),
        .r_nxt  (r_step_s),
        .q_nxt  (q_step_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RST_STATE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    load_s      = 1'b1;
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (cnt_r == CNT_ONE) begin
                    last_s      = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Iteration registers: radicand shifter, partial remainder, partial root, step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r   <= {WIDTH{1'b0}};
            r_r   <= {(N+1){1'b0}};
            q_r   <= {N{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            x_r   <= bus.in_data;
            r_r   <= {(N+1){1'b0}};
            q_r   <= {N{1'b0}};
            cnt_r <= CNT_LOAD;
        end else if (step_s) begin
            x_r   <= x_r << 2'd2;
            r_r   <= r_step_s;
            q_r   <= q_step_s;
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            x_r   <= x_r;
            r_r   <= r_r;
            q_r   <= q_r;
            cnt_r <= cnt_r;
        end
    end

    // Result registers are loaded on the final step so they stay put while Q/R restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= RST_IN_READY;
            out_valid_r <= RST_OUT_VALID;
            out_root_r  <= {N{1'b0}};
            out_rem_r   <= {(N+1){1'b0}};
        end else begin
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            if (last_s) begin
                out_root_r <= q_step_s;
                out_rem_r  <= r_step_s;
            end else begin
                out_root_r <= out_root_r;
                out_rem_r  <= out_rem_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_root  = out_root_r;
    assign bus.out_rem   = out_rem_r;

`ifdef SQRT_EXACT_FLAG_EN
    logic out_exact_r;

    // Exact flag is only high while the result is being presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_exact_r <= RST_OUT_EXACT;
        end else if (last_s) begin
            out_exact_r <= (r_step_s == {(N+1){1'b0}});
        end else if (state_nxt_s == DONE) begin
            out_exact_r <= out_exact_r;
        end else begin
            out_exact_r <= 1'b0;
        end
    end

    assign bus.out_exact = out_exact_r;
`endif

endmodule

// File: tb/tb_sequential_isqrt.sv
// Scoreboard bench for sequential_isqrt (WIDTH=6): reset, latency, backpressure, exhaustive streaming.
// With SQRT_EXACT_FLAG_EN defined the out_exact flag is checked as well.
module tb_sequential_isqrt;
    localparam int WIDTH = 6;
    localparam int N     = WIDTH / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sequential_isqrt_if #(.WIDTH(WIDTH)) bus ();

    sequential_isqrt #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int unsigned data;
        int unsigned root;
        int unsigned rem;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_m;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int unsigned v);
        exp_t e;
        e.data = v;
        e.root = 0;
        for (int r = 0; r < (1 << N); r++) begin
            if (r * r <= v) e.root = r;
        end
        e.rem = v - e.root * e.root;
        return e;
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) sb.push_back(model(int'(bus.in_data)));
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got root=%0d rem=%0d, expected no result", bus.out_root, bus.out_rem);
                end else begin
                    e_m = sb.pop_front();
                    checks++;
                    if (int'(bus.out_root) !== int'(e_m.root)) begin
                        errors++;
                        $display("FAIL sb_root data=%0d got %0d expected %0d", e_m.data, bus.out_root, e_m.root);
                    end
                    checks++;
                    if (int'(bus.out_rem) !== int'(e_m.rem)) begin
                        errors++;
                        $display("FAIL sb_rem data=%0d got %0d expected %0d", e_m.data, bus.out_rem, e_m.rem);
                    end
                    checks++;
                    if ((int'(bus.out_root) * int'(bus.out_root) + int'(bus.out_rem) != int'(e_m.data)) ||
                        (int'(bus.out_rem) > 2 * int'(bus.out_root))) begin
                        errors++;
                        $display("FAIL sb_identity data=%0d got root=%0d rem=%0d", e_m.data, bus.out_root, bus.out_rem);
                    end
`ifdef SQRT_EXACT_FLAG_EN
                    checks++;
                    if (bus.out_exact !== (e_m.rem == 0)) begin
                        errors++;
                        $display("FAIL sb_exact data=%0d got %0b expected %0b", e_m.data, bus.out_exact, (e_m.rem == 0));
                    end
`endif
                end
            end
        end
    end

    // Offer v and return #1 after the edge on which it was accepted.
    task automatic send(input int unsigned v);
        bit seen = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'(v);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.in_ready) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL send_timeout data=%0d in_ready never high", v);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d out_valid=%0b", sb.size(), bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #12;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_root !== 3'd0 || bus.out_rem !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got rdy=%0b vld=%0b root=%0d rem=%0d expected 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_root, bus.out_rem);
        end
`ifdef SQRT_EXACT_FLAG_EN
        checks++;
        if (bus.out_exact !== 1'b0) begin
            errors++;
            $display("FAIL reset_exact got %0b expected 0", bus.out_exact);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single(input int unsigned v, input int unsigned exp_root, input int unsigned exp_rem);
        bus.out_ready = 1'b1;
        send(v);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (k == 3)) begin
                errors++;
                $display("FAIL latency data=%0d cycle=%0d out_valid=%0b expected %0b", v, k, bus.out_valid, (k == 3));
            end
        end
        checks++;
        if (int'(bus.out_root) !== int'(exp_root) || int'(bus.out_rem) !== int'(exp_rem)) begin
            errors++;
            $display("FAIL single data=%0d got root=%0d rem=%0d expected %0d %0d", v, bus.out_root, bus.out_rem, exp_root, exp_rem);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_return data=%0d got rdy=%0b vld=%0b expected 1 0", v, bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_calc();
        bit stale = 1'b0;
        bus.out_ready = 1'b1;
        send(63);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_root !== 3'd0 || bus.out_rem !== 4'd0) begin
            errors++;
            $display("FAIL midcalc_reset got rdy=%0b vld=%0b root=%0d rem=%0d expected 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_root, bus.out_rem);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL midcalc_stale got a result or busy after reset, expected idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        bus.out_ready = 1'b0;
        send(50);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_timeout out_valid never high");
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_root !== 3'd7 || bus.out_rem !== 4'd1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got vld=%0b root=%0d rem=%0d rdy=%0b expected 1 7 1 0",
                         i, bus.out_valid, bus.out_root, bus.out_rem, bus.in_ready);
            end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_early got in_ready=%0b expected 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rdy=%0b vld=%0b expected 1 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int unsigned prev = 0;
        bit seen;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int v = 0; v < (1 << WIDTH); v++) begin
            bus.in_data = WIDTH'(v);
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.in_ready) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL b2b_timeout data=%0d in_ready never high", v);
            end else if (v > 0) begin
                checks++;
                if (cyc - prev != 5) begin
                    errors++;
                    $display("FAIL b2b_interval data=%0d got %0d expected 5", v, cyc - prev);
                end
            end
            prev = cyc;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        wait_drain();
    endtask

`ifdef SQRT_EXACT_FLAG_EN
    task automatic test_exact(input int unsigned v, input bit exp_exact);
        bus.out_ready = 1'b1;
        send(v);
        repeat (4) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_exact !== exp_exact) begin
            errors++;
            $display("FAIL exact data=%0d got vld=%0b exact=%0b expected 1 %0b", v, bus.out_valid, bus.out_exact, exp_exact);
        end
        @(negedge clk);
        checks++;
        if (bus.out_exact !== 1'b0) begin
            errors++;
            $display("FAIL exact_clear data=%0d got %0b expected 0", v, bus.out_exact);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single(0, 0, 0);
        test_single(36, 6, 0);
        test_single(63, 7, 14);
        test_reset_mid_calc();
        test_backpressure();
        test_back_to_back();
`ifdef SQRT_EXACT_FLAG_EN
        test_exact(49, 1'b1);
        test_exact(48, 1'b0);
`endif
        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
